// File: rtl/uart_param_core_if.sv
`timescale 1ns/1ps
// uart_param_core_if
//   Bus-side bundle of the UART core: TX/RX FIFO handshakes, FIFO levels,
//   sticky error flags and FSM state visibility.
//
//   Handshake rules:
//     tx_fifo_writeEn is a one-clock push of tx_fifo_dataIn. It is accepted
//     only while tx_fifo_full is low; a push while full is dropped.
//     rx_fifo_readEn is a one-clock pop. It takes effect only while
//     rx_fifo_empty is low. rx_fifo_dataOut is the RX head, valid whenever
//     rx_fifo_empty is low. It reads 0 when the FIFO is empty.
//     Levels, full and empty update on the clock after the push or pop.
//
//   master : bus side. Drives the pushes, pops and err_clear.
//   slave  : UART core. Drives the status, data out and debug state.
interface uart_param_core_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_BITS-1:0] tx_fifo_dataIn;
   logic                 tx_fifo_writeEn;
   logic                 tx_fifo_full;
   logic [LW-1:0]        tx_fifo_level;
   logic                 tx_busy;
   logic                 rx_fifo_readEn;
   logic [DATA_BITS-1:0] rx_fifo_dataOut;
   logic                 rx_fifo_empty;
   logic [LW-1:0]        rx_fifo_level;
   logic                 rx_parity_err;
   logic                 rx_frame_err;
   logic                 rx_overrun;
   logic                 err_clear;
   logic [2:0]           tx_state_dbg;
   logic [2:0]           rx_state_dbg;

   modport master (
      output tx_fifo_dataIn, tx_fifo_writeEn, rx_fifo_readEn, err_clear,
      input  tx_fifo_full, tx_fifo_level, tx_busy, rx_fifo_dataOut,
             rx_fifo_empty, rx_fifo_level, rx_parity_err, rx_frame_err,
             rx_overrun, tx_state_dbg, rx_state_dbg
   );

   modport slave (
      input  tx_fifo_dataIn, tx_fifo_writeEn, rx_fifo_readEn, err_clear,
      output tx_fifo_full, tx_fifo_level, tx_busy, rx_fifo_dataOut,
             rx_fifo_empty, rx_fifo_level, rx_parity_err, rx_frame_err,
             rx_overrun, tx_state_dbg, rx_state_dbg
   );
endinterface

// File: rtl/uart_param_core.sv
`timescale 1ns/1ps
// uart_param_fifo
//   Synchronous first-word-fall-through FIFO.
//   Ports:
//     clk, reset : clock and synchronous active-high reset.
//     push, din  : write request and write data.
//     pop        : read request.
//     dout       : head entry. Reads 0 when the FIFO is empty.
//     empty      : no entries held.
//     full       : D entries held.
//     level      : current occupancy.
//   A pop on empty is ignored. A push on full is accepted only when a pop
//   happens on the same clock.
module uart_param_fifo #(
   parameter int W = 8,
   parameter int D = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [W-1:0]         din,
   input  logic                 pop,
   output logic [W-1:0]         dout,
   output logic                 empty,
   output logic                 full,
   output logic [$clog2(D):0]   level
);
   localparam int AW = $clog2(D);

   logic [W-1:0]  mem [D];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(D));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// uart_param_core
//   16x-oversampled UART with TX and RX FIFOs, runtime parity (none/even/odd),
//   1 or 2 stop bits and sticky receive error flags.
//   Ports:
//     clk, reset       : clock and synchronous active-high reset.
//     baud_final_value : a tick is produced every baud_final_value+1 clocks.
//                        16 ticks make one bit time.
//     parity_mode      : 01 selects even parity, 10 odd parity, others none.
//     two_stop         : TX sends 2 stop bits. RX checks only the first.
//     tx               : serial output, idle high.
//     rx               : serial input, asynchronous to clk.
//     bus              : FIFO handshakes, status and debug state.
module uart_param_core #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int BAUD_W     = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BAUD_W-1:0] baud_final_value,
   input  logic [1:0]        parity_mode,
   input  logic              two_stop,
   output logic              tx,
   input  logic              rx,
   uart_param_core_if.slave  bus
);
   localparam int              BW       = $clog2(DATA_BITS);
   localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);

   function automatic logic par_en(input logic [1:0] m);
      return (m == 2'b01) || (m == 2'b10);
   endfunction

   // ---------------------------------------------------------------- baud
   // The >= compare lets the counter recover at once when
   // baud_final_value is lowered below the current count.
   logic [BAUD_W-1:0] baud_cnt;
   logic              tick;

   assign tick = (baud_cnt >= baud_final_value);

   always_ff @(posedge clk) begin
      if (reset)     baud_cnt <= '0;
      else if (tick) baud_cnt <= '0;
      else           baud_cnt <= baud_cnt + 1'b1;
   end

   // ---------------------------------------------------------------- TX
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   tx_state_t            tx_state, tx_state_n;
   logic [4:0]           tx_cnt, tx_cnt_n;
   logic [BW-1:0]        tx_bit, tx_bit_n;
   logic [DATA_BITS-1:0] tx_data, tx_data_n;
   logic [1:0]           tx_mode, tx_mode_n;
   logic                 tx_two, tx_two_n;
   logic                 tx_pop;
   logic                 tx_empty;
   logic [DATA_BITS-1:0] tx_head;
   logic                 tx_bit_end;
   logic                 tx_par;

   uart_param_fifo #(.W(DATA_BITS), .D(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.tx_fifo_writeEn && !bus.tx_fifo_full),
      .din   (bus.tx_fifo_dataIn),
      .pop   (tx_pop),
      .dout  (tx_head),
      .empty (tx_empty),
      .full  (bus.tx_fifo_full),
      .level (bus.tx_fifo_level)
   );

   // A second stop bit stretches the STOP state to 32 ticks.
   assign tx_bit_end = tick &&
      (tx_cnt == (((tx_state == TX_STOP) && tx_two) ? 5'd31 : 5'd15));
   assign tx_par = (^tx_data) ^ (tx_mode == 2'b10);

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_data  <= '0;
         tx_mode  <= '0;
         tx_two   <= 1'b0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_data  <= tx_data_n;
         tx_mode  <= tx_mode_n;
         tx_two   <= tx_two_n;
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_data_n  = tx_data;
      tx_mode_n  = tx_mode;
      tx_two_n   = tx_two;
      tx_pop     = 1'b0;
      if ((tx_state != TX_IDLE) && tick)
         tx_cnt_n = tx_bit_end ? 5'd0 : tx_cnt + 5'd1;
      case (tx_state)
         TX_IDLE:   if (tick && !tx_empty) tx_pop = 1'b1;
         TX_START:  if (tx_bit_end) begin
                       tx_state_n = TX_DATA;
                       tx_bit_n   = '0;
                    end
         TX_DATA:   if (tx_bit_end) begin
                       if (tx_bit == LAST_BIT)
                          tx_state_n = par_en(tx_mode) ? TX_PARITY : TX_STOP;
                       else
                          tx_bit_n = tx_bit + 1'b1;
                    end
         TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP;
         TX_STOP:   if (tx_bit_end) begin
                       // Chain straight into the next frame when data waits.
                       if (!tx_empty) tx_pop = 1'b1;
                       else           tx_state_n = TX_IDLE;
                    end
         default:   tx_state_n = TX_IDLE;
      endcase
      // Frame configuration is captured here and held for the whole frame.
      if (tx_pop) begin
         tx_data_n  = tx_head;
         tx_mode_n  = parity_mode;
         tx_two_n   = two_stop;
         tx_cnt_n   = '0;
         tx_state_n = TX_START;
      end
   end

   always_comb begin
      case (tx_state)
         TX_START:  tx = 1'b0;
         TX_DATA:   tx = tx_data[tx_bit];
         TX_PARITY: tx = tx_par;
         default:   tx = 1'b1;
      endcase
   end

   assign bus.tx_busy      = (tx_state != TX_IDLE);
   assign bus.tx_state_dbg = tx_state;

   // ---------------------------------------------------------------- RX
   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4,
      RX_BREAK  = 3'd5
   } rx_state_t;

   rx_state_t            rx_state, rx_state_n;
   logic [3:0]           rx_cnt, rx_cnt_n;
   logic [BW-1:0]        rx_bit, rx_bit_n;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
   logic [1:0]           rx_mode, rx_mode_n;
   logic                 rx_meta, rx_s;
   logic                 rx_mid;
   logic                 rx_push_req;
   logic                 set_par;
   logic                 set_frame;
   logic                 rx_full;
   logic                 set_overrun;

   uart_param_fifo #(.W(DATA_BITS), .D(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push_req),
      .din   (rx_shift),
      .pop   (bus.rx_fifo_readEn),
      .dout  (bus.rx_fifo_dataOut),
      .empty (bus.rx_fifo_empty),
      .full  (rx_full),
      .level (bus.rx_fifo_level)
   );

   // Once START has realigned the count, cnt==15 falls at mid-bit.
   assign rx_mid = tick && (rx_cnt == 4'd15);

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_mode  <= '0;
      end else begin
         rx_meta  <= rx;
         rx_s     <= rx_meta;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
         rx_mode  <= rx_mode_n;
      end
   end

   always_comb begin
      rx_state_n  = rx_state;
      rx_cnt_n    = rx_cnt;
      rx_bit_n    = rx_bit;
      rx_shift_n  = rx_shift;
      rx_mode_n   = rx_mode;
      rx_push_req = 1'b0;
      set_par     = 1'b0;
      set_frame   = 1'b0;
      if (tick && (rx_state inside {RX_DATA, RX_PARITY, RX_STOP}))
         rx_cnt_n = rx_mid ? 4'd0 : rx_cnt + 4'd1;
      case (rx_state)
         RX_IDLE:   if (tick && !rx_s) begin
                       rx_state_n = RX_START;
                       rx_cnt_n   = '0;
                       rx_mode_n  = parity_mode;
                    end
         // Half a bit later the line must still be low, otherwise it was a glitch.
         RX_START:  if (tick) begin
                       if (rx_cnt == 4'd7) begin
                          rx_cnt_n = '0;
                          if (!rx_s) begin
                             rx_state_n = RX_DATA;
                             rx_bit_n   = '0;
                          end else begin
                             rx_state_n = RX_IDLE;
                          end
                       end else begin
                          rx_cnt_n = rx_cnt + 4'd1;
                       end
                    end
         RX_DATA:   if (rx_mid) begin
                       rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
                       if (rx_bit == LAST_BIT)
                          rx_state_n = par_en(rx_mode) ? RX_PARITY : RX_STOP;
                       else
                          rx_bit_n = rx_bit + 1'b1;
                    end
         RX_PARITY: if (rx_mid) begin
                       set_par    = (rx_s != ((^rx_shift) ^ (rx_mode == 2'b10)));
                       rx_state_n = RX_STOP;
                    end
         // The frame is stored even with a bad stop bit. A low line then
         // parks in BREAK so a held-low line yields only one frame.
         RX_STOP:   if (rx_mid) begin
                       rx_push_req = 1'b1;
                       if (!rx_s) begin
                          set_frame  = 1'b1;
                          rx_state_n = RX_BREAK;
                       end else begin
                          rx_state_n = RX_IDLE;
                       end
                    end
         RX_BREAK:  if (rx_s) rx_state_n = RX_IDLE;
         default:   rx_state_n = RX_IDLE;
      endcase
   end

   // A simultaneous pop frees the slot, so that case is not an overrun.
   assign set_overrun = rx_push_req && rx_full && !bus.rx_fifo_readEn;

   // A new error on the clearing clock wins over err_clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rx_parity_err <= 1'b0;
         bus.rx_frame_err  <= 1'b0;
         bus.rx_overrun    <= 1'b0;
      end else begin
         bus.rx_parity_err <= (bus.rx_parity_err && !bus.err_clear) || set_par;
         bus.rx_frame_err  <= (bus.rx_frame_err  && !bus.err_clear) || set_frame;
         bus.rx_overrun    <= (bus.rx_overrun    && !bus.err_clear) || set_overrun;
      end
   end

   assign bus.rx_state_dbg = rx_state;
endmodule

// File: tb/tb_uart_param_core.sv
`timescale 1ns/1ps
module tb_uart_param_core;
  localparam int DB = 8;
  localparam int FD = 8;
  localparam int BWD = 11;

  logic           clk = 1'b0;
  logic           reset;
  logic [BWD-1:0] baud_final_value;
  logic [1:0]     parity_mode;
  logic           two_stop;
  logic           tx;
  logic           rx;
  logic           rx_drv;
  logic           loopback;

  uart_param_core_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) bus ();

  uart_param_core #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .BAUD_W(BWD)) dut (
    .clk              (clk),
    .reset            (reset),
    .baud_final_value (baud_final_value),
    .parity_mode      (parity_mode),
    .two_stop         (two_stop),
    .tx               (tx),
    .rx               (rx),
    .bus              (bus)
  );

  assign rx = loopback ? tx : rx_drv;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [DB-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tx(input logic [DB-1:0] d);
    bus.tx_fifo_dataIn  = d;
    bus.tx_fifo_writeEn = 1'b1;
    step();
    bus.tx_fifo_writeEn = 1'b0;
  endtask

  task automatic pop_rx();
    bus.rx_fifo_readEn = 1'b1;
    step();
    bus.rx_fifo_readEn = 1'b0;
  endtask

  task automatic clear_err();
    bus.err_clear = 1'b1;
    step();
    bus.err_clear = 1'b0;
    step();
  endtask

  task automatic wait_tx_low(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (!tx) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_busy_low(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!bus.tx_busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Drives rx directly, bit 0 of bits first, 64 clocks per bit.
  task automatic drive_frame(input logic [11:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      rx_drv = bits[i];
      step(64);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pmode;
    logic        two;
    int          len;
    logic [11:0] bits;   // serial frame, bit 0 = start bit
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic        ok;
    logic [11:0] got;
    logic [DB-1:0] e;

    vecs[0] = '{8'h55, 2'b00, 1'b0, 10, 12'h2AA};
    vecs[1] = '{8'h0F, 2'b01, 1'b1, 12, 12'hC1E};
    vecs[2] = '{8'hA5, 2'b01, 1'b1, 12, 12'hD4A};
    vecs[3] = '{8'h3C, 2'b10, 1'b0, 11, 12'h678};
    vecs[4] = '{8'h01, 2'b10, 1'b0, 11, 12'h402};
    vecs[5] = '{8'hFF, 2'b11, 1'b1, 11, 12'h7FE};

    reset = 1'b1;
    baud_final_value = 11'd3;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    loopback = 1'b0;
    rx_drv = 1'b1;
    bus.tx_fifo_dataIn = '0;
    bus.tx_fifo_writeEn = 1'b0;
    bus.rx_fifo_readEn = 1'b0;
    bus.err_clear = 1'b0;
    step(3);

    // reset state
    chk("rst_tx", tx, 1);
    chk("rst_tx_busy", bus.tx_busy, 0);
    chk("rst_tx_level", bus.tx_fifo_level, 0);
    chk("rst_tx_full", bus.tx_fifo_full, 0);
    chk("rst_rx_empty", bus.rx_fifo_empty, 1);
    chk("rst_rx_level", bus.rx_fifo_level, 0);
    chk("rst_rx_data", bus.rx_fifo_dataOut, 0);
    chk("rst_flags", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}, 0);
    chk("rst_states", {bus.tx_state_dbg, bus.rx_state_dbg}, 0);
    reset = 1'b0;
    step(2);

    // table: TX waveform and loopback reception
    loopback = 1'b1;
    for (int v = 0; v < 6; v++) begin
      parity_mode = vecs[v].pmode;
      two_stop = vecs[v].two;
      push_tx(vecs[v].data);
      wait_tx_low(300, ok);
      chk("tx_start_seen", ok, 1);
      got = '0;
      for (int k = 1; k <= (vecs[v].len - 1) * 64 + 32; k++) begin
        step();
        if (k % 64 == 32) got[k / 64] = tx;
        if (k == 63) chk("tx_start_end", tx, 0);
        if (k == 64) chk("tx_first_data", tx, vecs[v].bits[1]);
      end
      chk("tx_frame", got, vecs[v].bits);
      wait_busy_low(200, ok);
      chk("tx_busy_drop", ok, 1);
      chk("tx_idle_high", tx, 1);
      chk("rx_loop_level", bus.rx_fifo_level, 1);
      chk("rx_loop_data", bus.rx_fifo_dataOut, vecs[v].data);
      chk("rx_loop_flags", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}, 0);
      pop_rx();
      chk("rx_loop_empty", bus.rx_fifo_empty, 1);
    end
    loopback = 1'b0;
    step(20);

    // RX parity error, frame error, err_clear
    parity_mode = 2'b10;
    drive_frame(12'h478, 11);
    rx_drv = 1'b1;
    step(100);
    chk("par_err_set", bus.rx_parity_err, 1);
    chk("par_err_no_frame", bus.rx_frame_err, 0);
    chk("par_err_data", bus.rx_fifo_dataOut, 8'h3C);
    pop_rx();
    parity_mode = 2'b00;
    drive_frame(12'h078, 10);
    step(20);
    chk("break_state", bus.rx_state_dbg, 3'd5);
    rx_drv = 1'b1;
    step(100);
    chk("frame_err_set", bus.rx_frame_err, 1);
    chk("par_err_sticky", bus.rx_parity_err, 1);
    chk("frame_err_level", bus.rx_fifo_level, 1);
    chk("frame_err_data", bus.rx_fifo_dataOut, 8'h3C);
    pop_rx();
    clear_err();
    chk("clear_flags", {bus.rx_parity_err, bus.rx_frame_err}, 0);

    // TX overflow with the baud generator stalled, then RX overrun
    reset = 1'b1;
    baud_final_value = 11'd2047;
    step(2);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) push_tx(8'h10 + 8'(k));
    chk("ovf_tx_level", bus.tx_fifo_level, 8);
    chk("ovf_tx_full", bus.tx_fifo_full, 1);
    chk("ovf_tx_idle", bus.tx_busy, 0);
    for (int k = 0; k < 8; k++) exp_q.push_back(8'h10 + 8'(k));
    loopback = 1'b1;
    baud_final_value = 11'd3;
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      step();
      if (bus.rx_fifo_level == 4'd8 && !bus.tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ovf_rx_fill", ok, 1);
    chk("ovf_tx_drained", bus.tx_fifo_level, 0);
    chk("ovf_no_overrun", bus.rx_overrun, 0);
    push_tx(8'h99);
    step(800);
    chk("ovr_busy_done", bus.tx_busy, 0);
    chk("ovr_set", bus.rx_overrun, 1);
    chk("ovr_level", bus.rx_fifo_level, 8);
    chk("ovr_head", bus.rx_fifo_dataOut, 8'h10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ovr_drain", bus.rx_fifo_dataOut, e);
      pop_rx();
    end
    chk("ovr_drained_empty", bus.rx_fifo_empty, 1);
    clear_err();
    chk("ovr_cleared", bus.rx_overrun, 0);
    loopback = 1'b0;

    // glitch on idle rx
    step(20);
    rx_drv = 1'b0;
    step(8);
    rx_drv = 1'b1;
    step(1200);
    chk("glitch_empty", bus.rx_fifo_empty, 1);
    chk("glitch_rx_idle", bus.rx_state_dbg, 0);
    chk("glitch_flags", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}, 0);

    // reset during a TX data bit
    push_tx(8'h5A);
    push_tx(8'h33);
    wait_tx_low(300, ok);
    chk("rst_mid_start", ok, 1);
    step(96);
    chk("rst_mid_busy", bus.tx_busy, 1);
    chk("rst_mid_level", bus.tx_fifo_level, 1);
    reset = 1'b1;
    step();
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy_clr", bus.tx_busy, 0);
    chk("rst_mid_level_clr", bus.tx_fifo_level, 0);
    reset = 1'b0;
    step(200);
    chk("rst_mid_stays_idle", {tx, bus.tx_busy}, 2'b10);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
